// File: rtl/cflog_writer_pkg.sv
// rtl/cflog_writer_pkg.sv - shared types and helpers for the CF-Log writer
package cflog_writer_pkg;

  typedef enum logic [1:0] {
    K_APPEND    = 2'd0,
    K_MARK      = 2'd1,
    K_OVERWRITE = 2'd2
  } entry_kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_HI = 2'd1,
    S_WR_LO = 2'd2,
    S_FLUSH = 2'd3
  } wr_state_e;

  // kind + 16-bit address + 32-bit word pair
  localparam int ENTRY_W = 2 + 16 + 32;

  typedef struct packed {
    entry_kind_e kind;
    logic [15:0] addr;
    logic [15:0] upper;
    logic [15:0] lower;
  } entry_t;

  // A marker pair must fit completely inside the log region
  function automatic logic in_region(input logic [15:0] addr,
                                     input logic [15:0] lo_lim,
                                     input logic [15:0] hi_lim);
    logic [15:0] last_pair;
    last_pair = hi_lim - 16'd2;
    return (addr >= lo_lim) && (addr <= last_pair);
  endfunction

endpackage

// File: rtl/cflog_entry_queue.sv
// rtl/cflog_entry_queue.sv - synchronous FIFO of pending log entries
module cflog_entry_queue #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cflog_writer.sv
// rtl/cflog_writer.sv - serialises CF-Log entries into a 16-bit log memory
module cflog_writer
  import cflog_writer_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cflow_hw_wen,
  input  logic [15:0] cflow_src,
  input  logic [15:0] cflow_dest,
  input  logic        detect_active,
  input  logic        detect_repeat,
  input  logic [15:0] active_block_cflog_addr,
  input  logic [15:0] spec_upper,
  input  logic [15:0] spec_lower,
  input  logic        write_cached,
  input  logic [15:0] cached_src,
  input  logic [15:0] cached_dest,
  input  logic [15:0] CFLOG_min,
  input  logic [15:0] CFLOG_max,
  input  logic        flush_ack,
  output logic        cflog_wr_en,
  output logic [15:0] cflog_wr_addr,
  output logic [15:0] cflog_wr_data,
  output logic [15:0] cflow_log_ptr,
  output logic        flush_req,
  output logic        overflow,
  output logic        busy
);

  logic                        det_q;
  logic                        det_rise;
  logic                        live_req;
  entry_t                      req_entry;
  logic                        req_valid;
  logic                        req_drop;
  logic                        q_full;
  logic                        q_empty;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  logic [ENTRY_W-1:0]          q_head_bits;
  entry_t                      q_head;
  logic                        q_pop;
  logic [15:0]                 head_tgt;
  logic [15:0]                 ptr_plus2;
  logic                        need_flush;

  wr_state_e                   state;
  entry_kind_e                 cur_kind;
  logic [15:0]                 cur_tgt;
  logic [15:0]                 cur_upper;
  logic [15:0]                 cur_lower;

  assign det_rise = detect_active & ~det_q;
  // Live entries are suppressed while a block detection owns the log
  assign live_req = cflow_hw_wen & ~detect_active;

  // Arbitrate the three request sources; the block marker always wins
  always_comb begin
    req_entry = '0;
    req_valid = 1'b0;
    req_drop  = 1'b0;
    if (det_rise) begin
      req_entry.kind  = detect_repeat ? K_OVERWRITE : K_MARK;
      req_entry.addr  = active_block_cflog_addr;
      req_entry.upper = spec_upper;
      req_entry.lower = spec_lower;
      req_valid = in_region(active_block_cflog_addr, CFLOG_min, CFLOG_max);
      req_drop  = ~req_valid | write_cached | live_req;
    end else if (write_cached) begin
      req_entry.kind  = K_APPEND;
      req_entry.upper = cached_src;
      req_entry.lower = cached_dest;
      req_valid = 1'b1;
      req_drop  = live_req;
    end else if (live_req) begin
      req_entry.kind  = K_APPEND;
      req_entry.upper = cflow_src;
      req_entry.lower = cflow_dest;
      req_valid = 1'b1;
    end
  end

  cflog_entry_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (req_valid),
    .push_data (req_entry),
    .pop       (q_pop),
    .pop_data  (q_head_bits),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign q_head     = entry_t'(q_head_bits);
  assign q_pop      = (state == S_IDLE) && !q_empty;
  assign head_tgt   = (q_head.kind == K_APPEND) ? cflow_log_ptr : q_head.addr;
  assign ptr_plus2  = cflow_log_ptr + 16'd2;
  assign need_flush = (q_head.kind == K_APPEND) && (ptr_plus2 > CFLOG_max);
  assign busy       = (q_count != '0) || (state != S_IDLE);

  // Detection edge register and sticky loss flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      det_q <= detect_active;
      if (req_drop || (req_valid && q_full)) overflow <= 1'b1;
    end
  end

  // Write sequencer: pop, optionally wait for a flush, then two word writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cur_kind      <= K_APPEND;
      cur_tgt       <= '0;
      cur_upper     <= '0;
      cur_lower     <= '0;
      cflog_wr_en   <= 1'b0;
      cflog_wr_addr <= '0;
      cflog_wr_data <= '0;
      flush_req     <= 1'b0;
      cflow_log_ptr <= CFLOG_min;
    end else begin
      case (state)
        S_IDLE: begin
          cflog_wr_en <= 1'b0;
          if (q_pop) begin
            cur_kind  <= q_head.kind;
            cur_tgt   <= head_tgt;
            cur_upper <= q_head.upper;
            cur_lower <= q_head.lower;
            if (need_flush) begin
              flush_req <= 1'b1;
              state     <= S_FLUSH;
            end else begin
              cflog_wr_en   <= 1'b1;
              cflog_wr_addr <= {head_tgt[15:1], 1'b0};
              cflog_wr_data <= q_head.upper;
              state         <= S_WR_HI;
            end
          end
        end
        S_WR_HI: begin
          cflog_wr_en   <= 1'b1;
          cflog_wr_addr <= {cur_tgt[15:1], 1'b0} + 16'd2;
          cflog_wr_data <= cur_lower;
          state         <= S_WR_LO;
        end
        S_WR_LO: begin
          cflog_wr_en <= 1'b0;
          if (cur_kind != K_OVERWRITE) cflow_log_ptr <= cur_tgt + 16'd4;
          state <= S_IDLE;
        end
        S_FLUSH: begin
          if (flush_ack) begin
            flush_req     <= 1'b0;
            cflow_log_ptr <= CFLOG_min;
            cur_tgt       <= CFLOG_min;
            cflog_wr_en   <= 1'b1;
            cflog_wr_addr <= {CFLOG_min[15:1], 1'b0};
            cflog_wr_data <= cur_upper;
            state         <= S_WR_HI;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cflog_writer.md
CFLOG_WRITER -- requirements
Module: cflog_writer

Interface
REQ-001 Parameter: QUEUE_DEPTH, default 4, pending-entry queue depth (power of two).
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cflow_hw_wen / cflow_src / cflow_dest  in  1/16/16  live CF-Log entry strobe and its word pair.
REQ-005 detect_active / detect_repeat  in  1/1  block-detection active and repeat-speculation flags.
REQ-006 active_block_cflog_addr  in  16  byte address where the detected block's marker belongs.
REQ-007 spec_upper / spec_lower  in  16/16  marker or repeat-counter word pair.
REQ-008 write_cached / cached_src / cached_dest  in  1/16/16  FIFO-drained entry strobe and its word pair.
REQ-009 CFLOG_min / CFLOG_max  in  16/16  first and last byte address of the CF-Log region (both even).
REQ-010 flush_ack  in  1  log consumer has emptied the log.
REQ-011 cflog_wr_en / cflog_wr_addr / cflog_wr_data  out  1/16/16  single-word log memory write port.
REQ-012 cflow_log_ptr  out  16  committed byte pointer to the next free entry.
REQ-013 flush_req / overflow / busy  out  1/1/1  log-full request, sticky dropped-request flag, queue or FSM non-idle.

Function
REQ-014 Entry kinds: APPEND (write pair at ptr, ptr += 4), MARK (write pair at addr, ptr = addr + 4), OVERWRITE (write pair at addr, ptr unchanged).
REQ-015 Rising edge of detect_active with detect_repeat=0 SHALL enqueue MARK {active_block_cflog_addr, spec_upper, spec_lower}.
REQ-016 Rising edge of detect_active with detect_repeat=1 SHALL enqueue OVERWRITE with the same fields.
REQ-017 write_cached=1 SHALL enqueue APPEND {cached_src, cached_dest}.
REQ-018 cflow_hw_wen=1 with detect_active=0 SHALL enqueue APPEND {cflow_src, cflow_dest}; cflow_hw_wen while detect_active=1 is ignored.
REQ-019 At most one enqueue per cycle, priority MARK/OVERWRITE > cached > live; each losing request SHALL set overflow.
REQ-020 Enqueue while queue full SHALL drop the request and set overflow; overflow clears only on reset.
REQ-021 FSM states IDLE, WR_HI, WR_LO, FLUSH; IDLE pops the head entry and enters WR_HI when the queue is non-empty.
REQ-022 WR_HI: cflog_wr_en=1, address = target, data = first word; WR_LO: cflog_wr_en=1, address = target + 2, data = second word, then IDLE.
REQ-023 Target = cflow_log_ptr for APPEND, entry address otherwise; cflow_log_ptr updates at the WR_LO edge.
REQ-024 Entry enqueued at edge N SHALL produce its WR_HI write in cycle N+2 when the FSM is idle (pop at N+1).
REQ-025 APPEND popped with ptr + 2 > CFLOG_max SHALL enter FLUSH instead of WR_HI.
REQ-026 FLUSH: flush_req=1; on flush_ack, ptr := CFLOG_min, then WR_HI for the held entry.
REQ-027 MARK/OVERWRITE with address outside [CFLOG_min, CFLOG_max-2] SHALL be discarded and set overflow.
REQ-028 Address arithmetic is 16-bit modulo; bit 0 of every write address is 0.
REQ-029 Enqueues continue during FLUSH; the queue is served in order.
REQ-030 busy = queue non-empty or FSM not IDLE.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear: queue empty, FSM IDLE, cflog_wr_en=0, cflog_wr_addr=0, cflog_wr_data=0, flush_req=0, overflow=0, busy=0.
REQ-032 Reset SHALL set cflow_log_ptr=CFLOG_min and the detect_active edge register to 0.
REQ-033 Reset mid-write SHALL abandon the entry; no further write strobe for it after release.

Structure
REQ-034 Shared package holds: entry-kind enum (APPEND, MARK, OVERWRITE), FSM state enum, entry width constant (kind + 16 addr + 32 data).
REQ-035 One sub-module: cflog_entry_queue (synchronous FIFO with full/empty/occupancy), instantiated once.

Verification
REQ-036 CFLOG_min=0x6000, three live entries (0xE010,0xE020)... -> writes at 0x6000-0x600A, cflow_log_ptr=0x600C.
REQ-037 ptr=0x6010, detect_active rises, addr=0x6008, spec=(0x1111,0x0005) -> writes 0x6008=0x1111, 0x600A=0x0005; ptr=0x600C.
REQ-038 detect_repeat=1, detect_active rises, addr=0x6004, counter 0x0000_0003 -> writes 0x6004=0x0000, 0x6006=0x0003; ptr unchanged.
REQ-039 CFLOG_max=0x601E, ptr=0x6020, APPEND -> flush_req=1 until flush_ack; then write at 0x6000, ptr=0x6004.
REQ-040 Five write_cached pulses while FSM stalled in FLUSH (depth 4) -> fifth dropped, overflow=1; four entries written in order.
REQ-041 reset_n low during WR_HI -> all outputs zero immediately, ptr=CFLOG_min, no WR_LO write after release.
